alu_seq: RTL and testbench

Parametrised multi-cycle integer ALU for the Stage datapath, successor to the single-cycle execute-stage ALU. It keeps that block's 4-bit operation encoding and adds arithmetic right shift, unsigned compare and iterative multiply/divide/remainder. Results are returned through a valid/ready handshake, so the pipeline stalls on long operations instead of assuming single-cycle execute. One operation is in flight at a time.

---
 rtl/alu_seq_if.sv | 36 +++
 rtl/alu_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Request/response bundle for the multi-cycle ALU.
//               Request side : in_valid/in_ready handshake carrying op, a, b.
//               Response side: out_valid/out_ready handshake carrying
//                              result and zero; busy is a status flag.
//               master modport - the issuing pipeline stage
//               slave  modport - the ALU itself
// Revision    : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle integer ALU with valid/ready handshakes.
//               Single-cycle ops are evaluated at acceptance; MUL uses a
//               shift-add loop and DIVU/REMU a restoring divider, one bit
//               per cycle for WIDTH cycles. One operation in flight.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset
//               bus   - alu_seq_if.slave (in_valid, in_ready, op, a, b,
//                       out_valid, out_ready, result, zero, busy)
// Parameters  : WIDTH - operand/result width, power of two, >= 8
// Revision    : 1.0  initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  alu_seq_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_RSVD = 4'b1111;

  // Low two op bits of the iterative group: 00 MUL, 01 DIVU, 10 REMU
  localparam logic [1:0] K_MUL  = 2'b00;
  localparam logic [1:0] K_DIVU = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [SHW:0]     count;
  logic [1:0]       kind;
  logic [WIDTH-1:0] acc;      // MUL accumulator / DIV partial remainder
  logic [WIDTH-1:0] opa;      // MUL shifted multiplicand / DIV quotient-dividend
  logic [WIDTH-1:0] opb;      // MUL shifted multiplier / DIV divisor
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             out_valid_q;

  logic             accept;
  logic             iter_op;
  logic             last_iter;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] quick_result;
  logic             quick_zero;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign accept    = bus.in_valid && (state == IDLE);
  assign iter_op   = (bus.op[3:2] == 2'b11) && (bus.op != OP_RSVD);
  assign last_iter = (state == BUSY) && (count == (SHW+1)'(1));
  assign shamt     = bus.b[SHW-1:0];

  // Handshake outputs depend only on registered state
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == BUSY);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = iter_op ? BUSY : DONE;
      BUSY: if (last_iter) state_next = DONE;
      DONE: if (out_valid_q && bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Single-cycle operations, evaluated on the live request at acceptance
  // --------------------------------------------------------------------------
  always_comb begin
    quick_result = '0;
    quick_zero   = 1'b0;
    case (bus.op)
      OP_ADD:  quick_result = bus.a + bus.b;
      OP_AND:  quick_result = bus.a & bus.b;
      OP_OR:   quick_result = bus.a | bus.b;
      OP_SLL:  quick_result = bus.a << shamt;
      OP_SLT:  quick_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SRL:  quick_result = bus.a >> shamt;
      OP_SUB:  quick_result = bus.a - bus.b;
      OP_XOR:  quick_result = bus.a ^ bus.b;
      OP_BEQ:  quick_zero   = (bus.a == bus.b);
      OP_BNE:  quick_zero   = (bus.a != bus.b);
      OP_SRA:  quick_result = WIDTH'($signed(bus.a) >>> shamt);
      OP_SLTU: quick_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      default: begin
        quick_result = '0;
        quick_zero   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Iteration step. The divider shifts the next dividend bit (MSB of opa)
  // into the partial remainder and keeps the trial subtraction when it does
  // not borrow. A zero divisor never borrows, so the quotient fills with ones
  // and the remainder ends up equal to the dividend with no special case.
  // --------------------------------------------------------------------------
  assign mul_sum   = acc + (opb[0] ? opa : '0);
  assign div_shift = {acc, opa[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ok    = !div_diff[WIDTH];
  assign rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {opa[WIDTH-2:0], div_ok};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      kind        <= '0;
      acc         <= '0;
      opa         <= '0;
      opb         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // out_valid trails entry into DONE by one cycle and drops at transfer
      out_valid_q <= (state == DONE) && !(out_valid_q && bus.out_ready);

      case (state)
        IDLE: begin
          if (accept) begin
            if (iter_op) begin
              // MUL and DIV share one load: acc=0, opa=a, opb=b
              kind  <= bus.op[1:0];
              count <= (SHW+1)'(WIDTH);
              acc   <= '0;
              opa   <= bus.a;
              opb   <= bus.b;
            end else begin
              result_q <= quick_result;
              zero_q   <= quick_zero;
            end
          end
        end
        BUSY: begin
          count <= count - (SHW+1)'(1);
          if (kind == K_MUL) begin
            acc <= mul_sum;
            opa <= {opa[WIDTH-2:0], 1'b0};
            opb <= {1'b0, opb[WIDTH-1:1]};
          end else begin
            acc <= rem_next;
            opa <= quo_next;
          end
          if (last_iter) begin
            zero_q <= 1'b0;
            if (kind == K_MUL) begin
              result_q <= mul_sum;
            end else if (kind == K_DIVU) begin
              result_q <= quo_next;
            end else begin
              result_q <= rem_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (WIDTH 32 and 8).
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // Issue one op to the 32-bit DUT, measure latency and busy cycles, take the result.
  task automatic do_op32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt, output logic [31:0] r, output logic z);
    @(negedge clk);
    bus32.op = o; bus32.a = x; bus32.b = y; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0; bus32.a = '1; bus32.b = '1;
    lat = 0; bcnt = 0;
    if (bus32.busy) bcnt++;
    while (!bus32.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (bus32.busy) bcnt++;
    end
    r = bus32.result; z = bus32.zero;
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
  endtask

  task automatic do_op8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output int bcnt, output logic [7:0] r, output logic z);
    @(negedge clk);
    bus8.op = o; bus8.a = x; bus8.b = y; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0; bus8.a = '1; bus8.b = '1;
    lat = 0; bcnt = 0;
    if (bus8.busy) bcnt++;
    while (!bus8.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (bus8.busy) bcnt++;
    end
    r = bus8.result; z = bus8.zero;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus32.out_valid); end
    n_cmp++; if (bus32.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus32.busy); end
    n_cmp++; if (bus32.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h want=0", bus32.result); end
    n_cmp++; if (bus32.zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got=%b want=0", bus32.zero); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", bus32.in_ready); end
  endtask

  task automatic test_single();
    logic [3:0]  ops [11] = '{4'h6, 4'h4, 4'hB, 4'hA, 4'h0, 4'h1, 4'h2, 4'h7, 4'h3, 4'h5, 4'hF};
    logic [31:0] va  [11] = '{32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                              32'hF0F0F0F0, 32'hF0000000, 32'hFFFF0000, 32'h1, 32'h80000000, 32'h1};
    logic [31:0] vb  [11] = '{32'h7, 32'h1, 32'h1, 32'h24, 32'h2,
                              32'h0FF00FF0, 32'h0000000F, 32'h0F0F0F0F, 32'h21, 32'hFFFFFFFF, 32'h1};
    logic [31:0] ve  [11] = '{32'hFFFFFFFE, 32'h1, 32'h0, 32'hF8000000, 32'h1,
                              32'h00F000F0, 32'hF000000F, 32'hF0F00F0F, 32'h2, 32'h1, 32'h0};
    int lat, bcnt; logic [31:0] r; logic z;
    for (int i = 0; i < 11; i++) begin
      do_op32(ops[i], va[i], vb[i], lat, bcnt, r, z);
      n_cmp++; if (r !== ve[i]) begin n_fail++; $display("FAIL single_result op=%h got=%h want=%h", ops[i], r, ve[i]); end
      n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL single_zero op=%h got=%b want=0", ops[i], z); end
      n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL single_latency op=%h got=%0d want=1", ops[i], lat); end
    end
  endtask

  task automatic test_branch();
    logic [3:0]  ops [4] = '{4'h8, 4'h9, 4'h9, 4'h8};
    logic [31:0] vb  [4] = '{32'h1234, 32'h1234, 32'h1235, 32'h1235};
    logic        ez  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int lat, bcnt; logic [31:0] r; logic z;
    for (int i = 0; i < 4; i++) begin
      do_op32(ops[i], 32'h1234, vb[i], lat, bcnt, r, z);
      n_cmp++; if (z !== ez[i]) begin n_fail++; $display("FAIL branch_zero op=%h got=%b want=%b", ops[i], z, ez[i]); end
      n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL branch_result op=%h got=%h want=0", ops[i], r); end
    end
  endtask

  task automatic test_iterative();
    logic [3:0]  ops [5] = '{4'hC, 4'hD, 4'hE, 4'hD, 4'hE};
    logic [31:0] va  [5] = '{32'hFFFFFFFF, 32'd100, 32'd100, 32'd9, 32'd9};
    logic [31:0] vb  [5] = '{32'd3, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] ve  [5] = '{32'hFFFFFFFD, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd9};
    int lat, bcnt; logic [31:0] r; logic z;
    for (int i = 0; i < 5; i++) begin
      do_op32(ops[i], va[i], vb[i], lat, bcnt, r, z);
      n_cmp++; if (r !== ve[i]) begin n_fail++; $display("FAIL iter_result op=%h got=%h want=%h", ops[i], r, ve[i]); end
      n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL iter_latency op=%h got=%0d want=33", ops[i], lat); end
      n_cmp++; if (bcnt != 32) begin n_fail++; $display("FAIL iter_busy_cycles op=%h got=%0d want=32", ops[i], bcnt); end
      n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL iter_zero op=%h got=%b want=0", ops[i], z); end
    end
  endtask

  task automatic test_reset_busy();
    int seen;
    @(negedge clk);
    bus32.op = 4'hC; bus32.a = 32'd5; bus32.b = 32'd3; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (bus32.busy !== 1'b1) begin n_fail++; $display("FAIL rstbusy_pre_busy got=%b want=1", bus32.busy); end
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus32.busy !== 1'b0) begin n_fail++; $display("FAIL rstbusy_busy got=%b want=0", bus32.busy); end
    n_cmp++; if (bus32.result !== 32'h0) begin n_fail++; $display("FAIL rstbusy_result got=%h want=0", bus32.result); end
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstbusy_out_valid got=%b want=0", bus32.out_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstbusy_in_ready got=%b want=1", bus32.in_ready); end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus32.out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rstbusy_stale_valid got=%0d want=0", seen); end
  endtask

  task automatic test_backpressure();
    int wait_cyc;
    @(negedge clk);
    bus32.op = 4'h0; bus32.a = 32'd3; bus32.b = 32'd4; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    wait_cyc = 0;
    while (!bus32.out_valid && wait_cyc < 50) begin @(posedge clk); #1; wait_cyc++; end
    n_cmp++; if (bus32.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_timeout got=%b want=1", bus32.out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus32.in_valid = i[0]; bus32.op = 4'h6; bus32.a = 32'd100; bus32.b = 32'd1;
      @(posedge clk); #1;
      n_cmp++; if (bus32.result !== 32'd7 || bus32.zero !== 1'b0 || bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got res=%h z=%b ov=%b ir=%b want res=7 z=0 ov=1 ir=0",
                 i, bus32.result, bus32.zero, bus32.out_valid, bus32.in_ready);
      end
    end
    @(negedge clk);
    bus32.op = 4'h7; bus32.a = 32'd1; bus32.b = 32'd3; bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    n_cmp++; if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_transfer got ov=%b ir=%b want ov=0 ir=1", bus32.out_valid, bus32.in_ready);
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    n_cmp++; if (bus32.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept got ir=%b want=0", bus32.in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bus32.out_valid !== 1'b1 || bus32.result !== 32'd2) begin
      n_fail++; $display("FAIL bp_next_result got ov=%b res=%h want ov=1 res=2", bus32.out_valid, bus32.result);
    end
    @(negedge clk); bus32.out_ready = 1'b1;
    @(posedge clk); #1; bus32.out_ready = 1'b0;
  endtask

  task automatic test_width8();
    int lat, bcnt; logic [7:0] r; logic z;
    do_op8(4'hC, 8'h10, 8'h10, lat, bcnt, r, z);
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL w8_mul_result got=%h want=00", r); end
    n_cmp++; if (lat != 9) begin n_fail++; $display("FAIL w8_mul_latency got=%0d want=9", lat); end
    n_cmp++; if (bcnt != 8) begin n_fail++; $display("FAIL w8_mul_busy got=%0d want=8", bcnt); end
    do_op8(4'hD, 8'hFF, 8'h10, lat, bcnt, r, z);
    n_cmp++; if (r !== 8'h0F) begin n_fail++; $display("FAIL w8_divu_result got=%h want=0f", r); end
    n_cmp++; if (lat != 9) begin n_fail++; $display("FAIL w8_divu_latency got=%0d want=9", lat); end
    do_op8(4'hE, 8'hFF, 8'h10, lat, bcnt, r, z);
    n_cmp++; if (r !== 8'h0F) begin n_fail++; $display("FAIL w8_remu_result got=%h want=0f", r); end
  endtask

  initial begin
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.op = 4'h0; bus32.a = '0; bus32.b = '0;
    bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0; bus8.op  = 4'h0; bus8.a  = '0; bus8.b  = '0;
    test_reset();
    test_single();
    test_branch();
    test_iterative();
    test_reset_busy();
    test_backpressure();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
